mc_ctrl_fsm: RTL and testbench

- Multicycle main control unit for the 32-bit MIPS-style datapath.
- Decodes opcode/funct and sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath enable, every mux select, and the 3-bit `select` code consumed by the ALU (encoder side of that code).
- Sits between the instruction register and the datapath; waits on a memory-ready handshake.

---
 rtl/mc_ctrl_fsm.sv | 185 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS main control FSM; optional bne support under MC_CTRL_BNE_EN
// Moore outputs are registered from the next state; only ir_write/pc_write see mem_ready/zero.
module mc_ctrl_fsm #(
    parameter int ALU_SEL_W = 3,
    parameter int STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic [1:0]           pc_src,
    output logic                 illegal,
    output logic [STATE_W-1:0]   state
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    typedef struct packed {
        logic                 iord;
        logic                 mem_read;
        logic                 mem_write;
        logic                 reg_write;
        logic                 reg_dst;
        logic                 mem_to_reg;
        logic                 alu_src_a;
        logic [1:0]           alu_src_b;
        logic [ALU_SEL_W-1:0] alu_select;
        logic [1:0]           pc_src;
        logic                 jump_write;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [ALU_SEL_W-1:0] SEL_AND = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] SEL_OR  = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] SEL_ADD = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] SEL_SUB = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] SEL_JMP = ALU_SEL_W'(6);

    state_t               state_q, state_d;
    ctrl_t                ctrl_q, ctrl_d;
    logic                 illegal_q;
    logic                 funct_ok;
    logic [ALU_SEL_W-1:0] funct_sel;
    logic                 branch_taken;

    always_comb begin
        funct_ok  = 1'b1;
        funct_sel = SEL_AND;
        case (funct)
            6'b100000: funct_sel = SEL_ADD;
            6'b100010: funct_sel = SEL_SUB;
            6'b100100: funct_sel = SEL_AND;
            6'b100101: funct_sel = SEL_OR;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:    state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
                    6'b000101:    state_d = S_BRANCH;
`endif
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = funct_ok ? S_ALUWB : S_HALT;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH:  begin ctrl_d.mem_read = 1'b1; ctrl_d.alu_src_b = 2'b01; ctrl_d.alu_select = SEL_ADD; end
            S_DECODE: begin ctrl_d.alu_src_b = 2'b11; ctrl_d.alu_select = SEL_ADD; end
            S_MEMADR, S_ADDIEX: begin
                ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_src_b = 2'b10; ctrl_d.alu_select = SEL_ADD;
            end
            S_MEMRD:  begin ctrl_d.mem_read = 1'b1; ctrl_d.iord = 1'b1; end
            S_MEMWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.mem_to_reg = 1'b1; end
            S_MEMWR:  begin ctrl_d.mem_write = 1'b1; ctrl_d.iord = 1'b1; end
            S_EXEC:   begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_select = funct_sel; end
            S_ALUWB:  begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; end
            S_BRANCH: begin ctrl_d.alu_src_a = 1'b1; ctrl_d.alu_select = SEL_SUB; ctrl_d.pc_src = 2'b01; end
            S_ADDIWB: ctrl_d.reg_write = 1'b1;
            S_JUMP:   begin ctrl_d.pc_src = 2'b10; ctrl_d.alu_select = SEL_JMP; ctrl_d.jump_write = 1'b1; end
            default:  ctrl_d = '0;
        endcase
    end

`ifdef MC_CTRL_BNE_EN
    logic is_bne_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
`ifdef MC_CTRL_BNE_EN
            is_bne_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_q | (state_d == S_HALT);
`ifdef MC_CTRL_BNE_EN
            if (state_q == S_DECODE) is_bne_q <= (opcode == 6'b000101);
`endif
        end
    end

`ifdef MC_CTRL_BNE_EN
    assign branch_taken = is_bne_q ? ~zero : zero;
`else
    assign branch_taken = zero;
`endif

    // Fetch strobes complete with the memory handshake, so they cannot be registered.
    assign ir_write   = (state_q == S_FETCH) & mem_ready;
    assign pc_write   = ir_write | ((state_q == S_BRANCH) & branch_taken) | ctrl_q.jump_write;
    assign iord       = ctrl_q.iord;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_select = ctrl_q.alu_select;
    assign pc_src     = ctrl_q.pc_src;
    assign illegal    = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm (honours MC_CTRL_BNE_EN)
module tb_mc_ctrl_fsm;

    localparam logic [3:0] S_RST = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP = 4'd12, S_HALT = 4'd13;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_select;
    logic       illegal;
    logic [3:0] state;
    logic [15:0] dut_ctrl;

    typedef struct packed {
        logic [3:0]  st;
        logic        ill;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic ill_exp = 1'b0;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_select(alu_select), .pc_src(pc_src),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_ctrl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                       mem_to_reg, alu_src_a, alu_src_b, alu_select, pc_src};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference output table, written straight from the per-state output list.
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic [5:0] op,
                                             input logic [5:0] fn, input logic mr, input logic z);
        logic pw, irw, iod, mrd, mwr, rw, rd, m2r, sa, taken;
        logic [1:0] sb, ps;
        logic [2:0] sel;
        {pw, irw, iod, mrd, mwr, rw, rd, m2r, sa} = '0;
        sb = 2'b00; ps = 2'b00; sel = 3'b000;
`ifdef MC_CTRL_BNE_EN
        taken = (op == 6'b000101) ? ~z : z;
`else
        taken = z;
`endif
        case (st)
            S_FETCH:  begin mrd = 1; sb = 2'b01; sel = 3'b010; irw = mr; pw = mr; end
            S_DECODE: begin sb = 2'b11; sel = 3'b010; end
            S_MEMADR: begin sa = 1; sb = 2'b10; sel = 3'b010; end
            S_MEMRD:  begin mrd = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iod = 1; end
            S_EXEC: begin
                sa = 1;
                case (fn)
                    6'b100000: sel = 3'b010;
                    6'b100010: sel = 3'b011;
                    6'b100101: sel = 3'b001;
                    default:   sel = 3'b000;
                endcase
            end
            S_ALUWB:  begin rw = 1; rd = 1; end
            S_BRANCH: begin sa = 1; sel = 3'b011; ps = 2'b01; pw = taken; end
            S_ADDIEX: begin sa = 1; sb = 2'b10; sel = 3'b010; end
            S_ADDIWB: rw = 1;
            S_JUMP:   begin ps = 2'b10; sel = 3'b110; pw = 1; end
            default:  ;
        endcase
        return {pw, irw, iod, mrd, mwr, rw, rd, m2r, sa, sb, sel, ps};
    endfunction

    task automatic cyc(input logic mr, input logic z, input logic [3:0] st);
        exp_t e;
        @(negedge clk);
        mem_ready = mr;
        zero = z;
        if (st == S_HALT) ill_exp = 1'b1;
        sb_q.push_back('{st: st, ill: ill_exp, ctrl: exp_ctrl(st, opcode, funct, mr, z)});
        #1;
        e = sb_q.pop_front();
        check($sformatf("state(op=%b)", opcode), 32'(state), 32'(e.st));
        check($sformatf("ctrl@state%0d", e.st), 32'(dut_ctrl), 32'(e.ctrl));
        check("illegal", 32'(illegal), 32'(e.ill));
        check("rd_wr_excl", 32'(mem_read & mem_write), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        ill_exp = 1'b0;
        check("rst_state", 32'(state), 32'(S_RST));
        check("rst_ctrl", 32'(dut_ctrl), 32'(0));
        check("rst_illegal", 32'(illegal), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fetch_decode();
        cyc(1'b1, 1'b0, S_FETCH);
        cyc(1'b1, 1'b0, S_DECODE);
    endtask

    initial begin
        logic [5:0] r_fn [3];
        r_fn = '{6'b100100, 6'b100101, 6'b100000};
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'b0; funct = 6'b0;
        do_reset();
        cyc(1'b1, 1'b0, S_RST);

        opcode = 6'b000000; funct = 6'b100010;
        fetch_decode();
        cyc(1'b1, 1'b0, S_EXEC);
        cyc(1'b1, 1'b0, S_ALUWB);

        for (int i = 0; i < 3; i++) begin
            funct = r_fn[i];
            cyc(1'b0, 1'b0, S_FETCH);
            fetch_decode();
            cyc(1'b1, 1'b0, S_EXEC);
            cyc(1'b1, 1'b0, S_ALUWB);
        end

        opcode = 6'b100011;
        fetch_decode();
        cyc(1'b1, 1'b0, S_MEMADR);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, S_MEMRD);
        cyc(1'b1, 1'b0, S_MEMRD);
        cyc(1'b1, 1'b0, S_MEMWB);

        opcode = 6'b000100;
        for (int i = 1; i >= 0; i--) begin
            fetch_decode();
            cyc(1'b1, 1'(i), S_BRANCH);
        end

        opcode = 6'b001000;
        fetch_decode();
        cyc(1'b1, 1'b0, S_ADDIEX);
        cyc(1'b1, 1'b0, S_ADDIWB);

        opcode = 6'b101011;
        fetch_decode();
        cyc(1'b1, 1'b0, S_MEMADR);
        cyc(1'b0, 1'b0, S_MEMWR);
        cyc(1'b1, 1'b0, S_MEMWR);

        opcode = 6'b000010;
        fetch_decode();
        cyc(1'b1, 1'b0, S_JUMP);

        opcode = 6'b000101;
        fetch_decode();
`ifdef MC_CTRL_BNE_EN
        cyc(1'b1, 1'b0, S_BRANCH);
        fetch_decode();
        cyc(1'b1, 1'b1, S_BRANCH);
`else
        cyc(1'b1, 1'b0, S_HALT);
`endif
        do_reset();
        cyc(1'b1, 1'b0, S_RST);

        opcode = 6'b000000; funct = 6'b101010;
        fetch_decode();
        cyc(1'b1, 1'b0, S_EXEC);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, S_HALT);
        do_reset();
        cyc(1'b1, 1'b0, S_RST);

        opcode = 6'b111111;
        fetch_decode();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, S_HALT);
        do_reset();
        cyc(1'b1, 1'b0, S_RST);

        // Abort a stalled store: reset must act before the next clock edge.
        opcode = 6'b101011;
        fetch_decode();
        cyc(1'b1, 1'b0, S_MEMADR);
        cyc(1'b0, 1'b0, S_MEMWR);
        #1 rst = 1'b1;
        #1;
        ill_exp = 1'b0;
        check("abort_state", 32'(state), 32'(S_RST));
        check("abort_mem_write", 32'(mem_write), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b1, 1'b0, S_RST);

        opcode = 6'b000010;
        fetch_decode();
        cyc(1'b1, 1'b0, S_JUMP);
        cyc(1'b0, 1'b0, S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
